gray_pos_decoder: RTL and testbench
===================================

Name: gray_pos_decoder

Overview:
- Receive-side counterpart to the team's binary-to-Gray encoder: samples a Gray-coded bus from an external absolute encoder or clock-domain crossing and converts it back to binary.
- Synchronises and filters the bus, decodes Gray to binary, detects single-step direction and illegal multi-step jumps, and keeps a signed position accumulator.
- Sits between the asynchronous Gray source and downstream control logic.

Parameters:
- WIDTH, 4, Gray/binary code width (>=2)
- SYNC_STAGES, 2, input synchroniser depth (>=2)
- STABLE_CYC, 2, consecutive identical synchronised samples required to accept a code (>=1)
- POSW, 16, position accumulator width (two's complement)

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- g_in  input  WIDTH  Gray code from source, asynchronous to clk
- en  input  1  1 = acceptance enabled; 0 = hold decoded state
- clr_pos  input  1  synchronous clear of pos and fault
- bin_out  output  WIDTH  last accepted code, decoded to binary
- valid  output  1  one-cycle pulse when bin_out is (re)loaded
- dir  output  1  1 = last step up, 0 = down; held between steps
- step_err  output  1  one-cycle pulse on an illegal jump
- fault  output  1  sticky illegal-jump flag
- pos  output  POSW  signed step count

Behaviour:
- Decided: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: sync chain, candidate, counter, bin_out, pos = 0; valid, dir, step_err, fault = 0; state = S_INIT.
- Sync: g_in passes through SYNC_STAGES flops; the output is s.
- Filter:
  - If s != cand: cand <= s, cnt <= 0.
  - Otherwise cnt increments (saturating).
  - A code is accepted when cnt reaches STABLE_CYC-1 and cand != the last accepted code. S_INIT accepts regardless.
  - Glitches shorter than STABLE_CYC post-sync cycles are never accepted.
- Latency: g_in change held stable -> bin_out/valid update exactly SYNC_STAGES+STABLE_CYC+1 rising edges later (5 with defaults).
- Decode: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. The result is registered into bin_out.
- Step computation: delta = new_bin - old_bin mod 2^WIDTH.
- FSM:
  - S_INIT: first accepted code loads bin_out and pulses valid. pos is unchanged, no step_err. Go to S_TRACK.
  - S_TRACK:
    - delta == 1: dir <= 1, pos <= pos+1.
    - delta == 2^WIDTH-1: dir <= 0, pos <= pos-1.
    - Any other delta: step_err pulse, fault <= 1, pos unchanged, dir unchanged; go to S_FAULT.
    - In all three cases bin_out loads and valid pulses.
  - S_FAULT: bin_out/valid keep tracking accepted codes; pos and dir frozen; no further step_err pulses. clr_pos -> S_TRACK.
- Wrap-around: bin 2^WIDTH-1 -> 0 is a legal up step; 0 -> 2^WIDTH-1 is a legal down step.
- pos wraps two's complement at POSW bits; no saturation.
- clr_pos:
  - pos <= 0, fault <= 0, state S_FAULT -> S_TRACK.
  - Has priority over a same-cycle step's pos update. bin_out, valid and dir still update for that step; a same-cycle illegal jump is ignored for step_err and fault.
- en = 0: sync chain and filter keep running; no acceptance, no valid/step/pos change. When en returns to 1, the current stable code is evaluated against the last accepted code as a normal step.
- rst_n asserted mid-operation: immediate return to reset values, including any step in progress; on release the FSM re-enters S_INIT.

Optional Feature:
GRAY_DEC_PARITY_EN
- Defined:
  - Adds input g_par (1 bit, synchronised alongside g_in) and output par_err (1 bit).
  - {g_par, code} must have even parity at acceptance time. On bad parity: code rejected (no valid, no state change), par_err pulses one cycle.
  - Same stable code is not re-flagged until it changes.
- Undefined: g_par and par_err ports absent; no parity check.

Test Plan (WIDTH=4, defaults):
1. Reset / first acceptance:
   - rst_n=0 with g_in=0011: all outputs 0.
   - Release: 5 edges later valid=1, bin_out=2, pos=0, step_err=0.
2. Up sweep: g_in 0000 -> 0001 -> 0011 -> 0010, each held 8 cycles -> bin_out 1, 2, 3; dir=1; pos=3; three valid pulses.
3. Wrap:
   - g_in 1000 (bin 15) -> 0000 -> bin_out=0, dir=1, pos+1.
   - Then 0000 -> 1000 -> dir=0, pos-1.
4. Glitch: from g_in=0000, pulse 0001 for one cycle -> no valid; bin_out stays 0; pos unchanged.
5. Jump and clear:
   - 0000 -> 0110 (bin 4) -> step_err pulse, fault=1, bin_out=4, pos frozen.
   - Further legal steps leave pos frozen.
   - clr_pos=1 -> pos=0, fault=0; next 0110 -> 0111 gives pos=1.
6. Mid-operation reset: assert rst_n 2 cycles after a g_in change -> outputs 0 immediately, no valid; after release, S_INIT re-acquires the held code with pos=0.

Source files
------------

// File: rtl/gray_pos_decoder.sv
// Gray-code position receiver: synchronise, debounce, decode, step-track, accumulate.
// Optional parity check on {g_par, g_in} when GRAY_DEC_PARITY_EN is defined.
module gray_pos_decoder #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2,
  parameter int POSW        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  g_in,
  input  logic              en,
  input  logic              clr_pos,
  output logic [WIDTH-1:0]  bin_out,
  output logic              valid,
  output logic              dir,
  output logic              step_err,
  output logic              fault,
  output logic [POSW-1:0]   pos
`ifdef GRAY_DEC_PARITY_EN
  ,
  input  logic              g_par,
  output logic              par_err
`endif
);

  // state   | meaning
  // S_INIT  | no code accepted since reset; next stable code loads without a step
  // S_TRACK | accepted codes produce +1/-1 steps on pos
  // S_FAULT | illegal jump seen; bin_out tracks, pos/dir frozen until clr_pos
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } state_t;

`ifdef GRAY_DEC_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif

  localparam int CW = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [SW-1:0]          sync_in;
  logic [SW-1:0]          sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] sync_vld;
  logic [SW-1:0]          s;
  logic                   s_vld;

  logic [SW-1:0]          cand;
  logic                   cand_vld;
  logic [CW-1:0]          cnt;

  logic [WIDTH-1:0]       cand_bin;
  logic [WIDTH-1:0]       delta;
  logic                   stable;
  logic                   evaluate;
  logic                   accept;
  logic                   step_up;
  logic                   step_dn;

  state_t                 state;

`ifdef GRAY_DEC_PARITY_EN
  logic                   par_flag;
  logic                   par_ok;
  logic                   par_rej;
  assign sync_in = {g_par, g_in};
`else
  assign sync_in = g_in;
`endif

  // sync_vld marks when the chain holds real samples rather than reset zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      sync_vld <= '0;
    end else begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s     = sync_q[SYNC_STAGES-1];
  assign s_vld = sync_vld[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= '0;
      cand_vld <= 1'b0;
      cnt      <= '0;
    end else if (!cand_vld || (s != cand)) begin
      cand     <= s;
      cand_vld <= s_vld;
      cnt      <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign cand_bin = gray_to_bin(cand[WIDTH-1:0]);
  assign delta    = cand_bin - bin_out;
  assign step_up  = (delta == WIDTH'(1));
  assign step_dn  = (delta == {WIDTH{1'b1}});
  assign stable   = cand_vld && (s == cand) && (cnt == CNT_MAX);
  assign evaluate = en && stable && ((state == S_INIT) || (cand_bin != bin_out));

`ifdef GRAY_DEC_PARITY_EN
  assign par_ok  = ~^cand;
  assign accept  = evaluate && par_ok && !par_flag;
  assign par_rej = evaluate && !par_ok && !par_flag;

  // a rejected code stays flagged until the candidate changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_flag <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      par_err <= par_rej;
      if (!cand_vld || (s != cand)) begin
        par_flag <= 1'b0;
      end else if (par_rej) begin
        par_flag <= 1'b1;
      end
    end
  end
`else
  assign accept = evaluate;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      bin_out  <= '0;
      valid    <= 1'b0;
      dir      <= 1'b0;
      step_err <= 1'b0;
      fault    <= 1'b0;
      pos      <= '0;
    end else begin
      valid    <= 1'b0;
      step_err <= 1'b0;
      if (accept) begin
        bin_out <= cand_bin;
        valid   <= 1'b1;
        case (state)
          S_INIT: begin
            state <= S_TRACK;
          end
          S_TRACK: begin
            if (step_up) begin
              dir <= 1'b1;
              if (!clr_pos) pos <= pos + POSW'(1);
            end else if (step_dn) begin
              dir <= 1'b0;
              if (!clr_pos) pos <= pos - POSW'(1);
            end else if (!clr_pos) begin
              step_err <= 1'b1;
              fault    <= 1'b1;
              state    <= S_FAULT;
            end
          end
          S_FAULT: begin
            // a step coinciding with the clear counts for direction only
            if (clr_pos && step_up) begin
              dir <= 1'b1;
            end else if (clr_pos && step_dn) begin
              dir <= 1'b0;
            end
          end
          default: begin
            state <= S_INIT;
          end
        endcase
      end
      if (clr_pos) begin
        pos   <= '0;
        fault <= 1'b0;
        if (state == S_FAULT) state <= S_TRACK;
      end
    end
  end

endmodule

// File: tb/tb_gray_pos_decoder.sv
// Directed bench for gray_pos_decoder: expected results queued at stimulus time,
// compared by an independent monitor on every valid pulse.
module tb_gray_pos_decoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  g_in;
  logic        en;
  logic        clr_pos;
  logic [3:0]  bin_out;
  logic        valid;
  logic        dir;
  logic        step_err;
  logic        fault;
  logic [15:0] pos;

  gray_pos_decoder #(
    .WIDTH(4), .SYNC_STAGES(2), .STABLE_CYC(2), .POSW(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .g_in     (g_in),
    .en       (en),
    .clr_pos  (clr_pos),
    .bin_out  (bin_out),
    .valid    (valid),
    .dir      (dir),
    .step_err (step_err),
    .fault    (fault),
    .pos      (pos)
  );

  typedef struct {
    logic [3:0]  bin;
    logic        dir;
    logic [15:0] pos;
    logic        serr;
    logic        fault;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_exp(input logic [3:0] b, input logic d, input logic [15:0] p,
                          input logic se, input logic f, input int lat);
    exp_t e;
    e.bin = b; e.dir = d; e.pos = p; e.serr = se; e.fault = f; e.cyc = cyc + lat;
    exp_q.push_back(e);
  endtask

  // call on a falling edge; g_in change reaches valid 5 rising edges later
  task automatic step(input logic [3:0] g, input logic [3:0] b, input logic d,
                      input logic [15:0] p, input logic se, input logic f);
    g_in = g;
    push_exp(b, d, p, se, f, 5);
    repeat (8) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (step_err && !valid) begin
        checks++;
        errors++;
        $display("FAIL stray_step_err: step_err=1 without valid (cycle %0d)", cyc);
      end
      if (valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: bin_out=%0d pos=%0d, no pulse expected (cycle %0d)",
                   bin_out, pos, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bin_out !== e.bin || dir !== e.dir || pos !== e.pos ||
              step_err !== e.serr || fault !== e.fault || cyc != e.cyc) begin
            errors++;
            $display("FAIL valid_pulse: got bin=%0d dir=%0b pos=%0d serr=%0b fault=%0b cyc=%0d expected bin=%0d dir=%0b pos=%0d serr=%0b fault=%0b cyc=%0d",
                     bin_out, dir, pos, step_err, fault, cyc,
                     e.bin, e.dir, e.pos, e.serr, e.fault, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] bb;
    rst_n   = 1'b0;
    g_in    = 4'b0011;
    en      = 1'b1;
    clr_pos = 1'b0;

    // reset state and first acquisition (gray 0011 = bin 2)
    repeat (3) @(negedge clk);
    #1;
    chk("rst_bin_out", 32'(bin_out), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_step_err", 32'(step_err), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_pos", 32'(pos), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'd2, 1'b0, 16'd0, 1'b0, 1'b0, 5);
    repeat (8) @(negedge clk);

    // restart from code 0 for the up sweep
    rst_n = 1'b0;
    g_in  = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 5);
    repeat (8) @(negedge clk);

    step(4'b0001, 4'd1, 1'b1, 16'd1, 1'b0, 1'b0);
    step(4'b0011, 4'd2, 1'b1, 16'd2, 1'b0, 1'b0);
    step(4'b0010, 4'd3, 1'b1, 16'd3, 1'b0, 1'b0);

    for (int b = 4; b < 16; b++) begin
      bb = 4'(b);
      step(bb ^ (bb >> 1), bb, 1'b1, 16'(b), 1'b0, 1'b0);
    end

    // wrap-around in both directions
    step(4'b0000, 4'd0,  1'b1, 16'd16, 1'b0, 1'b0);
    step(4'b1000, 4'd15, 1'b0, 16'd15, 1'b0, 1'b0);
    step(4'b0000, 4'd0,  1'b1, 16'd16, 1'b0, 1'b0);

    // one-cycle glitch must be filtered
    g_in = 4'b0001;
    @(negedge clk);
    g_in = 4'b0000;
    repeat (10) @(negedge clk);
    chk("glitch_bin_out", 32'(bin_out), 32'd0);
    chk("glitch_pos", 32'(pos), 32'd16);

    // illegal jump, frozen tracking, clear
    step(4'b0110, 4'd4, 1'b1, 16'd16, 1'b1, 1'b1);
    step(4'b0111, 4'd5, 1'b1, 16'd16, 1'b0, 1'b1);
    step(4'b0110, 4'd4, 1'b1, 16'd16, 1'b0, 1'b1);
    clr_pos = 1'b1;
    @(negedge clk);
    clr_pos = 1'b0;
    #1;
    chk("clr_pos_val", 32'(pos), 32'd0);
    chk("clr_fault", 32'(fault), 32'd0);
    @(negedge clk);
    step(4'b0111, 4'd5, 1'b1, 16'd1, 1'b0, 1'b0);

    // en low holds; re-enable evaluates the settled code next edge
    en   = 1'b0;
    g_in = 4'b0101;
    repeat (10) @(negedge clk);
    chk("en_hold_bin", 32'(bin_out), 32'd5);
    chk("en_hold_pos", 32'(pos), 32'd1);
    en = 1'b1;
    push_exp(4'd6, 1'b1, 16'd2, 1'b0, 1'b0, 1);
    repeat (4) @(negedge clk);

    // clr_pos coinciding with a legal step wins on pos only
    g_in = 4'b0100;
    push_exp(4'd7, 1'b1, 16'd0, 1'b0, 1'b0, 5);
    repeat (4) @(negedge clk);
    clr_pos = 1'b1;
    @(negedge clk);
    clr_pos = 1'b0;
    repeat (3) @(negedge clk);

    // reset in the middle of a pending step
    g_in = 4'b1100;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_bin_out", 32'(bin_out), 32'd0);
    chk("midrst_pos", 32'(pos), 32'd0);
    chk("midrst_dir", 32'(dir), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_exp(4'd8, 1'b0, 16'd0, 1'b0, 1'b0, 5);
    repeat (8) @(negedge clk);

    repeat (10) @(negedge clk);
    chk("pending_expectations", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
